scr1_dmem_responder: RTL and testbench

SCR1_DMEM_RESPONDER -- requirements
Module: scr1_dmem_responder

---
 rtl/scr1_dmem_responder_pkg.sv | 50 +++++
 rtl/scr1_dmem_resp_ram.sv | 42 ++++
 rtl/scr1_dmem_responder.sv | 184 ++++++++++++++++++
 tb/tb_scr1_dmem_responder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_dmem_responder_pkg.sv
// rtl/scr1_dmem_responder_pkg.sv - shared memif types and data-memory responder constants
//   Memory command/width/response enums, the responder FSM state enum,
//   bus widths, the wait-state ceiling and a byte-enable helper.
package scr1_dmem_responder_pkg;

    localparam int SCR1_DMEM_AWIDTH        = 32;
    localparam int SCR1_DMEM_DWIDTH        = 32;
    localparam int SCR1_DMEM_RESP_WAIT_MAX = 7;
    localparam int SCR1_DMEM_RESP_CNT_W    = $clog2(SCR1_DMEM_RESP_WAIT_MAX + 1);

    typedef enum logic [1:0] {
        SCR1_MEM_CMD_RD    = 2'b00,
        SCR1_MEM_CMD_WR    = 2'b01,
        SCR1_MEM_CMD_ERROR = 2'b11
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic [1:0] {
        SCR1_DMEM_RESP_FSM_IDLE = 2'b00,
        SCR1_DMEM_RESP_FSM_WAIT = 2'b01,
        SCR1_DMEM_RESP_FSM_RESP = 2'b10
    } type_scr1_dmem_resp_fsm_e;

    // Lanes touched by an access; write data arrives already lane-positioned.
    function automatic logic [3:0] scr1_dmem_byte_en(input type_scr1_mem_width_e width,
                                                     input logic [1:0]           lsb);
        logic [3:0] be;
        be = 4'b0000;
        unique case (width)
            SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << lsb;
            SCR1_MEM_WIDTH_HWORD: be = lsb[1] ? 4'b1100 : 4'b0011;
            SCR1_MEM_WIDTH_WORD:  be = 4'b1111;
            default:              be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/scr1_dmem_resp_ram.sv
// rtl/scr1_dmem_resp_ram.sv - single-port word RAM with byte enables and registered read
//   clk   : clock
//   en    : port access this cycle
//   we    : 1 = write enabled lanes, 0 = read word into output register
//   addr  : word index
//   be    : byte-lane enables for writes
//   wdata : write word
//   rdata : registered read word (holds until the next read)
module scr1_dmem_resp_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/scr1_dmem_responder.sv
// rtl/scr1_dmem_responder.sv - SCR1 data-memory responder with configurable wait states
//   clk, rst_n          : clock, asynchronous active-low reset
//   core2dmem_req_i     : request valid
//   core2dmem_cmd_i     : RD / WR / ERROR
//   core2dmem_width_i   : BYTE / HWORD / WORD / ERROR
//   core2dmem_addr_i    : byte address
//   core2dmem_wdata_i   : lane-positioned write data
//   dmem2core_req_ack_o : request accepted when high together with req
//   dmem2core_rdata_o   : read word, non-zero only in an OK read response cycle
//   dmem2core_resp_o    : NOTRDY / RDY_OK / RDY_ER
module scr1_dmem_responder
    import scr1_dmem_responder_pkg::*;
#(
    parameter int          MEM_DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          WAIT_STATES     = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          core2dmem_req_i,
    input  type_scr1_mem_cmd_e            core2dmem_cmd_i,
    input  type_scr1_mem_width_e          core2dmem_width_i,
    input  logic [SCR1_DMEM_AWIDTH-1:0]   core2dmem_addr_i,
    input  logic [SCR1_DMEM_DWIDTH-1:0]   core2dmem_wdata_i,
    output logic                          dmem2core_req_ack_o,
    output logic [SCR1_DMEM_DWIDTH-1:0]   dmem2core_rdata_o,
    output type_scr1_mem_resp_e           dmem2core_resp_o
);

    localparam int                              ADDR_W    = $clog2(MEM_DEPTH_WORDS);
    localparam logic [31:0]                     MEM_BYTES = 32'(MEM_DEPTH_WORDS * 4);
    localparam logic [SCR1_DMEM_RESP_CNT_W-1:0] CNT_LOAD  =
        (WAIT_STATES > 0) ? SCR1_DMEM_RESP_CNT_W'(WAIT_STATES - 1) : '0;

    type_scr1_dmem_resp_fsm_e        state_q, state_d;
    logic [SCR1_DMEM_RESP_CNT_W-1:0] cnt_q, cnt_d;
    type_scr1_mem_cmd_e              cmd_q, cmd_d;
    logic [ADDR_W-1:0]               idx_q, idx_d;
    logic [3:0]                      be_q, be_d;
    logic [31:0]                     wdata_q, wdata_d;
    logic                            err_q, err_d;

    logic        req_ack;
    logic        accept;
    logic [31:0] in_off;
    logic        in_err;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_idx;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    assign accept = core2dmem_req_i & req_ack;

    // Request decode; the offset subtraction wraps, so addresses below the
    // base are rejected explicitly rather than aliasing into the array.
    always_comb begin
        in_off = core2dmem_addr_i - BASE_ADDR;
        in_err = 1'b0;
        if ((core2dmem_cmd_i != SCR1_MEM_CMD_RD) && (core2dmem_cmd_i != SCR1_MEM_CMD_WR)) begin
            in_err = 1'b1;
        end
        unique case (core2dmem_width_i)
            SCR1_MEM_WIDTH_BYTE:  ;
            SCR1_MEM_WIDTH_HWORD: if (core2dmem_addr_i[0])          in_err = 1'b1;
            SCR1_MEM_WIDTH_WORD:  if (core2dmem_addr_i[1:0] != 2'b00) in_err = 1'b1;
            default:              in_err = 1'b1;
        endcase
        if ((core2dmem_addr_i < BASE_ADDR) || (in_off >= MEM_BYTES)) begin
            in_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCR1_DMEM_RESP_FSM_IDLE;
            cnt_q   <= '0;
            cmd_q   <= SCR1_MEM_CMD_RD;
            idx_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        if (accept) begin
            cmd_d   = core2dmem_cmd_i;
            idx_d   = in_off[ADDR_W+1:2];
            be_d    = scr1_dmem_byte_en(core2dmem_width_i, core2dmem_addr_i[1:0]);
            wdata_d = core2dmem_wdata_i;
            err_d   = in_err;
        end
        unique case (state_q)
            SCR1_DMEM_RESP_FSM_IDLE,
            SCR1_DMEM_RESP_FSM_RESP: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_d = SCR1_DMEM_RESP_FSM_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = SCR1_DMEM_RESP_FSM_RESP;
                    end
                end else begin
                    state_d = SCR1_DMEM_RESP_FSM_IDLE;
                end
            end
            SCR1_DMEM_RESP_FSM_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = SCR1_DMEM_RESP_FSM_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = SCR1_DMEM_RESP_FSM_IDLE;
        endcase
    end

    // The RAM is touched exactly once per transaction, in the cycle that
    // precedes RESP: the read lands in the RAM output register for RESP and
    // the write is visible to any later access. With no wait states that
    // cycle is the accept cycle, so the port is fed straight from the bus.
    always_comb begin
        if (WAIT_STATES == 0) begin
            ram_en    = accept & ~in_err;
            ram_we    = (core2dmem_cmd_i == SCR1_MEM_CMD_WR);
            ram_idx   = in_off[ADDR_W+1:2];
            ram_be    = scr1_dmem_byte_en(core2dmem_width_i, core2dmem_addr_i[1:0]);
            ram_wdata = core2dmem_wdata_i;
        end else begin
            ram_en    = (state_q == SCR1_DMEM_RESP_FSM_WAIT) && (cnt_q == '0) && !err_q;
            ram_we    = (cmd_q == SCR1_MEM_CMD_WR);
            ram_idx   = idx_q;
            ram_be    = be_q;
            ram_wdata = wdata_q;
        end
    end

    scr1_dmem_resp_ram #(
        .DEPTH  (MEM_DEPTH_WORDS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_idx),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        req_ack           = rst_n & ((state_q == SCR1_DMEM_RESP_FSM_IDLE) ||
                                     (state_q == SCR1_DMEM_RESP_FSM_RESP));
        dmem2core_resp_o  = SCR1_MEM_RESP_NOTRDY;
        dmem2core_rdata_o = '0;
        if (state_q == SCR1_DMEM_RESP_FSM_RESP) begin
            dmem2core_resp_o = err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            if (!err_q && (cmd_q == SCR1_MEM_CMD_RD)) begin
                dmem2core_rdata_o = ram_rdata;
            end
        end
    end

    assign dmem2core_req_ack_o = req_ack;

endmodule

// File: tb/tb_scr1_dmem_responder.sv
// tb/tb_scr1_dmem_responder.sv - self-checking bench for scr1_dmem_responder
module tb_scr1_dmem_responder;
    import scr1_dmem_responder_pkg::*;

    localparam type_scr1_mem_cmd_e   RD  = SCR1_MEM_CMD_RD;
    localparam type_scr1_mem_cmd_e   WR  = SCR1_MEM_CMD_WR;
    localparam type_scr1_mem_cmd_e   CER = SCR1_MEM_CMD_ERROR;
    localparam type_scr1_mem_width_e B   = SCR1_MEM_WIDTH_BYTE;
    localparam type_scr1_mem_width_e H   = SCR1_MEM_WIDTH_HWORD;
    localparam type_scr1_mem_width_e W   = SCR1_MEM_WIDTH_WORD;
    localparam type_scr1_mem_width_e WER = SCR1_MEM_WIDTH_ERROR;
    localparam type_scr1_mem_resp_e  NR  = SCR1_MEM_RESP_NOTRDY;
    localparam type_scr1_mem_resp_e  OK  = SCR1_MEM_RESP_RDY_OK;
    localparam type_scr1_mem_resp_e  ER  = SCR1_MEM_RESP_RDY_ER;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    logic                 req   [3];
    type_scr1_mem_cmd_e   cmd   [3];
    type_scr1_mem_width_e width [3];
    logic [31:0]          addr  [3];
    logic [31:0]          wdata [3];
    logic                 ack   [3];
    logic [31:0]          rdata [3];
    type_scr1_mem_resp_e  resp  [3];

    int vec_cnt = 0;
    int miss_cnt = 0;

    logic [31:0] mdl [3][16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: 1 wait state, instance 1: none, instance 2: 3 wait states, small array at a high base.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        scr1_dmem_responder #(
            .MEM_DEPTH_WORDS ((g == 2) ? 16 : 1024),
            .BASE_ADDR       ((g == 2) ? 32'h1000_0000 : 32'h0000_0000),
            .WAIT_STATES     ((g == 0) ? 1 : (g == 1) ? 0 : 3)
        ) u_dut (
            .clk                 (clk),
            .rst_n               (rst_n),
            .core2dmem_req_i     (req[g]),
            .core2dmem_cmd_i     (cmd[g]),
            .core2dmem_width_i   (width[g]),
            .core2dmem_addr_i    (addr[g]),
            .core2dmem_wdata_i   (wdata[g]),
            .dmem2core_req_ack_o (ack[g]),
            .dmem2core_rdata_o   (rdata[g]),
            .dmem2core_resp_o    (resp[g])
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : 3;
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 2) ? 32'h1000_0000 : 32'h0000_0000;
    endfunction

    function automatic logic [31:0] bytes_of(input int d);
        return (d == 2) ? 32'd64 : 32'd4096;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_resp(input string nm, input type_scr1_mem_resp_e act, input type_scr1_mem_resp_e exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %s want %s", nm, act.name(), exp.name());
        end
    endtask

    // Reference: legal if the command/width are known, the address is naturally
    // aligned for its size and lies inside [base, base+bytes). Writes update
    // the lanes covered by [addr, addr+size).
    function automatic void model_txn(input int d, input type_scr1_mem_cmd_e c,
                                      input type_scr1_mem_width_e w, input logic [31:0] a,
                                      input logic [31:0] wd, output type_scr1_mem_resp_e er,
                                      output logic [31:0] erd);
        int size;
        int idx;
        int lo;
        er  = ER;
        erd = 32'h0;
        case (w)
            B:       size = 1;
            H:       size = 2;
            W:       size = 4;
            default: size = 0;
        endcase
        if (c != RD && c != WR) return;
        if (size == 0) return;
        if ((a % 32'(size)) != 0) return;
        if (a < base_of(d) || a >= base_of(d) + bytes_of(d)) return;
        idx = int'((a - base_of(d)) / 4);
        lo  = int'(a % 4);
        er  = OK;
        if (c == RD) begin
            erd = mdl[d][idx];
        end else begin
            for (int i = lo; i < lo + size; i++) mdl[d][idx][8*i +: 8] = wd[8*i +: 8];
        end
    endfunction

    // Called at a negedge with the instance idle or in RESP; returns at the
    // negedge after the response cycle.
    task automatic do_txn(input int d, input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                          input logic [31:0] a, input logic [31:0] wd,
                          input type_scr1_mem_resp_e er, input logic [31:0] erd, input string nm);
        int acc;
        int n;
        cmd[d] = c; width[d] = w; addr[d] = a; wdata[d] = wd; req[d] = 1'b1;
        n = 0;
        while (ack[d] !== 1'b1 && n < 16) begin @(negedge clk); n++; end
        acc = cyc;
        @(negedge clk);
        req[d] = 1'b0;
        n = 0;
        while (resp[d] == NR && n < 16) begin @(negedge clk); n++; end
        chk({nm, " latency"}, 32'(cyc - acc), 32'(ws_of(d) + 1));
        chk_resp({nm, " resp"}, resp[d], er);
        chk({nm, " rdata"}, rdata[d], erd);
        @(negedge clk);
    endtask

    task automatic model_and_txn(input int d, input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                                 input logic [31:0] a, input logic [31:0] wd, input string nm);
        type_scr1_mem_resp_e er;
        logic [31:0]         erd;
        model_txn(d, c, w, a, wd, er, erd);
        do_txn(d, c, w, a, wd, er, erd, nm);
    endtask

    typedef struct {
        int                   d;
        type_scr1_mem_cmd_e   c;
        type_scr1_mem_width_e w;
        logic [31:0]          a;
        logic [31:0]          wd;
        type_scr1_mem_resp_e  er;
        logic [31:0]          erd;
    } vec_t;

    function automatic vec_t mk(input int d, input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                                input logic [31:0] a, input logic [31:0] wd,
                                input type_scr1_mem_resp_e er, input logic [31:0] erd);
        vec_t v;
        v.d = d; v.c = c; v.w = w; v.a = a; v.wd = wd; v.er = er; v.erd = erd;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vt [$];
        logic [31:0] seq_a [4];
        int          t;
        logic [31:0] ra;
        int          r;

        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; cmd[d] = RD; width[d] = W; addr[d] = 32'h0; wdata[d] = 32'h0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset ack d%0d", d), 32'(ack[d]), 32'd0);
            chk_resp($sformatf("reset resp d%0d", d), resp[d], NR);
            chk($sformatf("reset rdata d%0d", d), rdata[d], 32'h0);
        end
        rst_n = 1'b1;
        #1;
        chk("ack after release", 32'(ack[0]), 32'd1);
        @(negedge clk);

        // Directed vectors
        vt.push_back(mk(0, WR, W,   32'h10,   32'hDEAD_BEEF, OK, 32'h0));
        vt.push_back(mk(0, RD, W,   32'h10,   32'h0,         OK, 32'hDEAD_BEEF));
        vt.push_back(mk(0, WR, W,   32'h10,   32'h1122_3344, OK, 32'h0));
        vt.push_back(mk(0, WR, B,   32'h13,   32'hAA00_0000, OK, 32'h0));
        vt.push_back(mk(0, RD, W,   32'h10,   32'h0,         OK, 32'hAA22_3344));
        vt.push_back(mk(0, RD, H,   32'h11,   32'h0,         ER, 32'h0));
        vt.push_back(mk(0, RD, W,   32'h1000, 32'h0,         ER, 32'h0));
        vt.push_back(mk(0, WR, W,   32'h12,   32'hFFFF_FFFF, ER, 32'h0));
        vt.push_back(mk(0, WR, H,   32'h12,   32'h5566_0000, OK, 32'h0));
        vt.push_back(mk(0, RD, W,   32'h10,   32'h0,         OK, 32'h5566_3344));
        vt.push_back(mk(0, RD, B,   32'h12,   32'h0,         OK, 32'h5566_3344));
        vt.push_back(mk(0, CER, W,  32'h10,   32'h0,         ER, 32'h0));
        vt.push_back(mk(0, RD, WER, 32'h10,   32'h0,         ER, 32'h0));
        vt.push_back(mk(0, WR, W,   32'hFFC,  32'h0BAD_F00D, OK, 32'h0));
        vt.push_back(mk(0, RD, W,   32'hFFC,  32'h0,         OK, 32'h0BAD_F00D));
        vt.push_back(mk(0, WR, W,   32'h20,   32'h0,         OK, 32'h0));
        vt.push_back(mk(1, WR, W,   32'h0,    32'hA000_0000, OK, 32'h0));
        vt.push_back(mk(1, WR, W,   32'h4,    32'hA111_1111, OK, 32'h0));
        vt.push_back(mk(1, WR, W,   32'h8,    32'hA222_2222, OK, 32'h0));
        vt.push_back(mk(1, WR, W,   32'hC,    32'hA333_3333, OK, 32'h0));
        vt.push_back(mk(1, RD, W,   32'h4,    32'h0,         OK, 32'hA111_1111));
        vt.push_back(mk(2, WR, W,   32'h1000_0000, 32'h0102_0304, OK, 32'h0));
        vt.push_back(mk(2, WR, W,   32'h1000_003C, 32'h89AB_CDEF, OK, 32'h0));
        vt.push_back(mk(2, RD, W,   32'h1000_003C, 32'h0,         OK, 32'h89AB_CDEF));
        vt.push_back(mk(2, RD, W,   32'h0FFF_FFFC, 32'h0,         ER, 32'h0));
        vt.push_back(mk(2, RD, W,   32'h1000_0040, 32'h0,         ER, 32'h0));
        vt.push_back(mk(2, WR, B,   32'h1000_0041, 32'h0000_FF00, ER, 32'h0));
        vt.push_back(mk(2, RD, H,   32'h1000_0002, 32'h0,         OK, 32'h0102_0304));
        foreach (vt[i]) begin
            do_txn(vt[i].d, vt[i].c, vt[i].w, vt[i].a, vt[i].wd, vt[i].er, vt[i].erd,
                   $sformatf("vec%0d", i));
        end

        // No wait states: four back-to-back reads with req held high
        seq_a = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};
        cmd[1] = RD; width[1] = W;
        for (int c = 0; c <= 5; c++) begin
            chk($sformatf("b2b ack c%0d", c), 32'(ack[1]), 32'd1);
            if (c == 0 || c == 5) begin
                chk_resp($sformatf("b2b resp c%0d", c), resp[1], NR);
            end else begin
                chk_resp($sformatf("b2b resp c%0d", c), resp[1], OK);
                chk($sformatf("b2b rdata c%0d", c), rdata[1], seq_a[c-1]);
            end
            addr[1] = 32'(c * 4);
            req[1]  = (c < 4);
            @(negedge clk);
        end

        // Three wait states: req held through WAIT, accepted only in RESP
        t = 0;
        for (int c = 0; c <= 13; c++) begin
            chk($sformatf("ws3 ack c%0d", c), 32'(ack[2]), 32'((c % 4 == 0) || c > 12));
            if (c == 4 || c == 8 || c == 12) chk_resp($sformatf("ws3 resp c%0d", c), resp[2], OK);
            else                             chk_resp($sformatf("ws3 resp c%0d", c), resp[2], NR);
            if (c == 8)  chk("ws3 rdata rd1", rdata[2], 32'hCAFE_F00D);
            if (c == 12) chk("ws3 rdata rd2", rdata[2], 32'h0102_0304);
            case (t)
                0: begin cmd[2] = WR; width[2] = W; addr[2] = 32'h1000_0008; wdata[2] = 32'hCAFE_F00D; end
                1: begin cmd[2] = RD; width[2] = W; addr[2] = 32'h1000_0008; wdata[2] = 32'h0; end
                default: begin cmd[2] = RD; width[2] = W; addr[2] = 32'h1000_0000; wdata[2] = 32'h0; end
            endcase
            req[2] = (t < 3);
            if ((c % 4 == 0) && t < 3) t++;
            @(negedge clk);
        end

        // Reset during WAIT of a write: aborted, no response, no store
        cmd[0] = WR; width[0] = W; addr[0] = 32'h20; wdata[0] = 32'h1234_5678; req[0] = 1'b1;
        chk("abort pre ack", 32'(ack[0]), 32'd1);
        @(negedge clk);
        req[0] = 1'b0;
        chk("abort wait ack", 32'(ack[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort rst ack", 32'(ack[0]), 32'd0);
        chk_resp("abort rst resp", resp[0], NR);
        repeat (2) begin
            @(negedge clk);
            chk_resp("abort held resp", resp[0], NR);
            chk("abort held ack", 32'(ack[0]), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("abort release ack", 32'(ack[0]), 32'd1);
        @(negedge clk);
        do_txn(0, RD, W, 32'h20, 32'h0, OK, 32'h0, "abort readback");

        // Preload a 16-word window of every instance, then random traffic
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 16; i++) begin
                model_and_txn(d, WR, W, base_of(d) + 32'(i * 4), $urandom, "preload");
            end
        end
        for (int n = 0; n < 80; n++) begin
            int                   d;
            type_scr1_mem_cmd_e   c;
            type_scr1_mem_width_e w;
            d  = int'($urandom_range(0, 2));
            r  = int'($urandom_range(0, 9));
            ra = base_of(d) + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            if (r == 0)      ra = ra + bytes_of(d);
            else if (r == 1) ra = base_of(d) - 32'd4 + 32'($urandom_range(0, 3));
            r = int'($urandom_range(0, 15));
            c = (r == 0) ? CER : (r < 8) ? RD : WR;
            r = int'($urandom_range(0, 12));
            w = (r == 0) ? WER : (r < 5) ? B : (r < 9) ? H : W;
            model_and_txn(d, c, w, ra, $urandom, $sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
